// File: rtl/sound_pkg.sv
// Shared definitions for the sound channel control blocks: register map,
// NR4x bit positions, read-back masks and frame-sequencer step decode.
package sound_pkg;

  localparam logic [15:0] NR41_ADDR = 16'hFF20;
  localparam logic [15:0] NR42_ADDR = 16'hFF21;
  localparam logic [15:0] NR43_ADDR = 16'hFF22;
  localparam logic [15:0] NR44_ADDR = 16'hFF23;

  localparam int NR44_TRIG_BIT   = 7;
  localparam int NR44_SINGLE_BIT = 6;

  // Write-only bits read back as 1.
  localparam logic [7:0] NR41_RD_MASK = 8'hFF;
  localparam logic [7:0] NR44_RD_MASK = 8'hBF;

  localparam logic [2:0] ENV_STEP = 3'd7;

  // The length counter is clocked on the even frame steps.
  function automatic logic is_len_step(input logic [2:0] step);
    return ~step[0];
  endfunction

endpackage

// File: rtl/sound_noise_ctrl_if.sv
// CPU-side register bus shared by the sound channel control blocks.
interface sound_noise_ctrl_if;
    logic [15:0] a;
    logic [7:0]  din;
    logic        wr;
    logic        rd;
    logic [7:0]  dout;

    modport master (output a, din, wr, rd, input dout);
    modport slave  (input a, din, wr, rd, output dout);
endinterface

// File: rtl/sound_frame_seq.sv
// 512 Hz frame sequencer: prescaler plus 3-bit step counter producing the
// length-counter and volume-envelope clocks. Held cleared while disabled.
module sound_frame_seq
    import sound_pkg::*;
#(
    parameter int FS_DIV = 8192
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic clk_length_ctr,
    output logic clk_vol_env
);
    localparam int PRE_W = (FS_DIV > 1) ? $clog2(FS_DIV) : 1;

    logic [PRE_W-1:0] prescaler, prescaler_nxt;
    logic [2:0]       step, step_nxt;

    // NOTE: every variable driven here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        prescaler_nxt = '0;
        step_nxt      = '0;
        if (en) begin
            step_nxt = step;
            if (prescaler == PRE_W'(FS_DIV - 1)) begin
                step_nxt = step + 3'd1;
            end else begin
                prescaler_nxt = prescaler + PRE_W'(1);
            end
        end
    end

    // Clock outputs are decoded from the next step so they line up with the
    // step register rather than lagging it by a cycle.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prescaler      <= '0;
            step           <= '0;
            clk_length_ctr <= 1'b0;
            clk_vol_env    <= 1'b0;
        end else begin
            prescaler      <= prescaler_nxt;
            step           <= step_nxt;
            clk_length_ctr <= en & is_len_step(step_nxt);
            clk_vol_env    <= en & (step_nxt == ENV_STEP);
        end
    end

endmodule

// File: rtl/sound_noise_ctrl.sv
// Noise channel (channel 4) control front end: NR41-NR44 register file,
// trigger pulse stretcher and frame sequencer instance.
module sound_noise_ctrl
    import sound_pkg::*;
#(
    parameter int FS_DIV    = 8192,
    parameter int START_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    sound_noise_ctrl_if.slave    bus,
    input  logic                 sound_on,
    output logic [5:0]           length,
    output logic [3:0]           initial_volume,
    output logic                 envelope_increasing,
    output logic [2:0]           num_envelope_sweeps,
    output logic [3:0]           shift_clock_freq,
    output logic                 counter_width,
    output logic [2:0]           freq_dividing_ratio,
    output logic                 single,
    output logic                 start,
    output logic                 clk_length_ctr,
    output logic                 clk_vol_env
);
    localparam int CNT_W = $clog2(START_LEN);

    logic [7:0]       nr42, nr43;
    logic [CNT_W-1:0] start_cnt;
    logic             wr_en, trigger;

    assign wr_en   = bus.wr & sound_on;
    assign trigger = wr_en & (bus.a == NR44_ADDR) & bus.din[NR44_TRIG_BIT];

    assign {initial_volume, envelope_increasing, num_envelope_sweeps} = nr42;
    assign {shift_clock_freq, counter_width, freq_dividing_ratio}     = nr43;

    always_ff @(posedge clk) begin
        if (!rst || !sound_on) begin
            length    <= '0;
            nr42      <= '0;
            nr43      <= '0;
            single    <= 1'b0;
            start     <= 1'b0;
            start_cnt <= '0;
        end else begin
            if (wr_en) begin
                unique case (bus.a)
                    NR41_ADDR: length <= bus.din[5:0];
                    NR42_ADDR: nr42   <= bus.din;
                    NR43_ADDR: nr43   <= bus.din;
                    NR44_ADDR: single <= bus.din[NR44_SINGLE_BIT];
                    default: ;
                endcase
            end
            // A re-trigger reloads the count, so start never drops between pulses.
            if (trigger) begin
                start     <= 1'b1;
                start_cnt <= CNT_W'(START_LEN - 1);
            end else if (start) begin
                if (start_cnt == '0) start <= 1'b0;
                else                 start_cnt <= start_cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        bus.dout = 8'hFF;
        if (bus.rd) begin
            unique case (bus.a)
                NR41_ADDR: bus.dout = {2'b00, length} | NR41_RD_MASK;
                NR42_ADDR: bus.dout = nr42;
                NR43_ADDR: bus.dout = nr43;
                NR44_ADDR: bus.dout = {1'b0, single, 6'b0} | NR44_RD_MASK;
                default:   bus.dout = 8'hFF;
            endcase
        end
    end

    sound_frame_seq #(.FS_DIV(FS_DIV)) u_frame_seq (
        .clk            (clk),
        .rst            (rst),
        .en             (sound_on),
        .clk_length_ctr (clk_length_ctr),
        .clk_vol_env    (clk_vol_env)
    );

endmodule

// File: tb/tb_sound_noise_ctrl.sv
// Directed bench for sound_noise_ctrl with a shortened frame-sequencer divider.
module tb_sound_noise_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sound_on;
  logic [5:0] length;
  logic [3:0] initial_volume;
  logic       envelope_increasing;
  logic [2:0] num_envelope_sweeps;
  logic [3:0] shift_clock_freq;
  logic       counter_width;
  logic [2:0] freq_dividing_ratio;
  logic       single;
  logic       start;
  logic       clk_length_ctr;
  logic       clk_vol_env;

  int n_cmp = 0;
  int n_err = 0;

  sound_noise_ctrl_if bus ();

  sound_noise_ctrl #(.FS_DIV(16), .START_LEN(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .bus                 (bus),
    .sound_on            (sound_on),
    .length              (length),
    .initial_volume      (initial_volume),
    .envelope_increasing (envelope_increasing),
    .num_envelope_sweeps (num_envelope_sweeps),
    .shift_clock_freq    (shift_clock_freq),
    .counter_width       (counter_width),
    .freq_dividing_ratio (freq_dividing_ratio),
    .single              (single),
    .start               (start),
    .clk_length_ctr      (clk_length_ctr),
    .clk_vol_env         (clk_vol_env)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    bus.a   = addr;
    bus.din = data;
    bus.wr  = 1'b1;
    tick();
    bus.wr  = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    bus.a  = addr;
    bus.rd = 1'b1;
    #1;
    check(tag, {8'h00, bus.dout}, {8'h00, exp});
    bus.rd = 1'b0;
  endtask

  logic       prev_len;
  int         rise_pos[5];
  int         n_rise;
  int         vol_cnt;
  int         vol_first;

  initial begin
    rst      = 1'b0;
    sound_on = 1'b0;
    bus.a    = 16'h0000;
    bus.din  = 8'h00;
    bus.wr   = 1'b0;
    bus.rd   = 1'b0;

    // 1. reset state, then NR42 write/read-back
    tick(); tick();
    check("rst_start", {15'd0, start}, 16'd0);
    check("rst_len_clk", {15'd0, clk_length_ctr}, 16'd0);
    check("rst_env_clk", {15'd0, clk_vol_env}, 16'd0);
    check("rst_length", {10'd0, length}, 16'd0);
    check("dout_no_rd", {8'h00, bus.dout}, 16'h00FF);
    rst = 1'b1;
    sound_on = 1'b1;
    tick();
    bus_write(16'hFF21, 8'hA3);
    check("init_vol", {12'd0, initial_volume}, 16'hA);
    check("env_inc", {15'd0, envelope_increasing}, 16'd0);
    check("env_sweeps", {13'd0, num_envelope_sweeps}, 16'd3);
    bus_read("rd_ff21", 16'hFF21, 8'hA3);
    bus_read("rd_ff20", 16'hFF20, 8'hFF);
    bus_read("rd_other", 16'hFF24, 8'hFF);

    // 2. NR43 write, trigger with single set
    bus_write(16'hFF22, 8'h5B);
    bus_write(16'hFF23, 8'hC0);
    check("shift_freq", {12'd0, shift_clock_freq}, 16'd5);
    check("cnt_width", {15'd0, counter_width}, 16'd1);
    check("div_ratio", {13'd0, freq_dividing_ratio}, 16'd3);
    check("single_set", {15'd0, single}, 16'd1);
    check("start_c0", {15'd0, start}, 16'd1);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("start_hold", {15'd0, start}, 16'd1);
    end
    tick();
    check("start_end", {15'd0, start}, 16'd0);
    bus_read("rd_ff23_s1", 16'hFF23, 8'hFF);

    // 4. re-trigger two cycles into the pulse
    bus_write(16'hFF23, 8'h80);
    check("retrig_c0", {15'd0, start}, 16'd1);
    tick();
    check("retrig_c1", {15'd0, start}, 16'd1);
    bus_write(16'hFF23, 8'h80);
    check("retrig_c2", {15'd0, start}, 16'd1);
    for (int i = 3; i < 6; i++) begin
      tick();
      check("retrig_hold", {15'd0, start}, 16'd1);
    end
    tick();
    check("retrig_end", {15'd0, start}, 16'd0);
    bus_read("rd_ff23_s0", 16'hFF23, 8'hBF);

    // 5. sound_on low clears fields and freezes the sequencer
    bus_write(16'hFF20, 8'h2A);
    check("length_set", {10'd0, length}, 16'h2A);
    bus_write(16'hFF21, 8'hA3);
    sound_on = 1'b0;
    tick();
    check("off_length", {10'd0, length}, 16'd0);
    check("off_init_vol", {12'd0, initial_volume}, 16'd0);
    check("off_shift", {12'd0, shift_clock_freq}, 16'd0);
    check("off_len_clk", {15'd0, clk_length_ctr}, 16'd0);
    bus_write(16'hFF21, 8'hFF);
    bus_read("off_rd_ff21", 16'hFF21, 8'h00);
    for (int i = 0; i < 20; i++) tick();
    check("off_len_clk2", {15'd0, clk_length_ctr}, 16'd0);
    check("off_env_clk", {15'd0, clk_vol_env}, 16'd0);

    // 3. frame sequencer from a fresh sound_on rise, FS_DIV=16
    prev_len  = clk_length_ctr;
    n_rise    = 0;
    vol_cnt   = 0;
    vol_first = -1;
    sound_on  = 1'b1;
    for (int k = 0; k < 128; k++) begin
      tick();
      if (clk_length_ctr && !prev_len && n_rise < 5) begin
        rise_pos[n_rise] = k;
        n_rise++;
      end
      prev_len = clk_length_ctr;
      if (clk_vol_env) begin
        if (vol_first < 0) vol_first = k;
        vol_cnt++;
      end
    end
    check("len_rises", 16'(n_rise), 16'd5);
    check("len_rise0", 16'(rise_pos[0]), 16'd0);
    check("len_per_1", 16'(rise_pos[2] - rise_pos[1]), 16'd32);
    check("len_per_2", 16'(rise_pos[3] - rise_pos[2]), 16'd32);
    check("len_per_3", 16'(rise_pos[4] - rise_pos[3]), 16'd32);
    check("env_cycles", 16'(vol_cnt), 16'd16);
    check("env_first", 16'(vol_first), 16'd111);

    // 6. reset on the second cycle of a start pulse
    bus_write(16'hFF21, 8'hA3);
    bus_write(16'hFF23, 8'h80);
    check("pre_rst_start", {15'd0, start}, 16'd1);
    tick();
    rst = 1'b0;
    tick();
    check("rst_mid_start", {15'd0, start}, 16'd0);
    check("rst_mid_vol", {12'd0, initial_volume}, 16'd0);
    check("rst_mid_lclk", {15'd0, clk_length_ctr}, 16'd0);
    rst = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sound_noise_ctrl.md
Name: sound_noise_ctrl

Overview:
CPU-facing control front end for the noise channel (channel 4).
- Decodes CPU bus writes and reads at FF20–FF23 (NR41–NR44) and holds the register fields.
- Drives the noise channel's parameter inputs and generates a clean, stretched `start` pulse on trigger.
- Contains the 512 Hz frame sequencer that produces the length-counter and volume-envelope clocks.
- Sits between the CPU bus mux and the noise channel generator.

Parameters:
- FS_DIV, 8192: CPU clocks per frame-sequencer step (4.194304 MHz / 512 Hz).
- START_LEN, 4: width of the `start` pulse in clk cycles (≥2).

Ports:
- clk  in  1  CPU clock (4.194304 MHz).
- rst  in  1  Reset. Synchronous, active-low, sampled on posedge clk.
- a  in  16  CPU address.
- din  in  8  CPU write data.
- wr  in  1  Write strobe. One-cycle qualifier.
- rd  in  1  Read strobe. Qualifies `dout`.
- dout  out  8  Read data. Valid combinationally when rd=1 and the address is in FF20–FF23; otherwise 8'hFF.
- sound_on  in  1  NR52 bit 7 (master sound enable).
- length  out  6  NR41[5:0].
- initial_volume  out  4  NR42[7:4].
- envelope_increasing  out  1  NR42[3].
- num_envelope_sweeps  out  3  NR42[2:0].
- shift_clock_freq  out  4  NR43[7:4].
- counter_width  out  1  NR43[3].
- freq_dividing_ratio  out  3  NR43[2:0].
- single  out  1  NR44[6].
- start  out  1  Trigger pulse, registered.
- clk_length_ctr  out  1  256 Hz length clock, registered, 50% duty.
- clk_vol_env  out  1  64 Hz envelope clock, registered.

Behaviour:
- Reset (rst=0 at posedge clk):
  - All field registers, `start`, `clk_length_ctr`, `clk_vol_env` = 0.
  - Frame-step counter = 0; prescaler = 0.
- Writes (wr=1, a in FF20–FF23, sound_on=1) update the fields on the next posedge:
  - FF20: length ← din[5:0].
  - FF21: {initial_volume, envelope_increasing, num_envelope_sweeps} ← din.
  - FF22: {shift_clock_freq, counter_width, freq_dividing_ratio} ← din.
  - FF23: single ← din[6]. If din[7]=1, this is a trigger.
- Writes with sound_on=0 are ignored.
- While sound_on=0, all field registers and `start` are held at 0. Clearing is synchronous; it happens the cycle after sound_on falls.
- Reads:
  - FF20 → 8'hFF.
  - FF21 → NR42 value.
  - FF22 → NR43 value.
  - FF23 → {1'b1, single, 6'h3F}.
  - Any other address → 8'hFF.
- Trigger / start pulse:
  - On a trigger, `start`=1 from the next cycle for START_LEN cycles, then 0.
  - Field updates take effect in the same edge that raises `start`, so the channel latches the new NR43 values on the start edge.
  - A re-trigger while `start` is high restarts the width count; `start` stays high with no intervening low cycle.
  - A reset mid-pulse drops `start` to 0 immediately.
- Frame sequencer (prescaler and step counter):
  - Prescaler counts 0..FS_DIV-1 and wraps to 0.
  - On wrap, step advances 0→1→…→7→0 (3-bit wrap).
  - clk_length_ctr = 1 in steps 0, 2, 4, 6; 0 otherwise. Rising edge every 2 steps.
  - clk_vol_env = 1 in step 7 only.
  - The sequencer runs only when sound_on=1. When sound_on=0, prescaler, step, and both clock outputs are held at 0. The next rising edge of sound_on restarts from step 0.
- All outputs are registered. There is no combinational path from the bus to channel outputs. The only combinational path is `dout`.

Decomposition:
- Shared package sound_pkg:
  - Register address constants: NR41_ADDR=16'hFF20 … NR44_ADDR=16'hFF23.
  - NR44 trigger/single bit indices.
  - Unused-bit read masks: NR41 8'hFF, NR44 8'hBF.
  - Frame-step encodings for the length and envelope steps.
  - The same package will serve the other channel control blocks.
- One sub-module, sound_frame_seq: prescaler, step counter, and both clock outputs, parameterised by FS_DIV. It is reusable by channels 1–3.
- The register file and start stretcher live in the top-level module.

Test Plan:
1. Reset, then sound_on=1, then write FF21=8'hA3 → initial_volume=4'hA, envelope_increasing=0, num_envelope_sweeps=3'd3. Read FF21 → 8'hA3; read FF20 → 8'hFF.
2. Write FF22=8'h5B, then FF23=8'hC0 → shift_clock_freq=5, counter_width=1, freq_dividing_ratio=3. single=1 and start high for exactly 4 cycles, starting 1 cycle after the write. Read FF23 → 8'hFF.
3. With FS_DIV=16, run 128 cycles:
   - clk_length_ctr rises at steps 0, 2, 4, 6, i.e. every 32 cycles.
   - clk_vol_env is high for 16 cycles once per 128 cycles, during step 7.
4. Write FF23=8'h80, then again 2 cycles later → start stays continuously high for 2+4=6 cycles with no low gap.
5. With fields nonzero, drop sound_on → all fields 0 the next cycle, sequencer frozen at step 0. A write FF21=8'hFF is ignored and read-back stays 8'h00.
6. Assert rst=0 on the 2nd cycle of a start pulse → start=0 and all fields 0 on the next posedge.
